// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage. Keeps the program counter, requests one
//   instruction word at a time from memory over a req/rdy handshake,
//   latches the returned word into an instruction register and offers it
//   downstream over a valid/ack handshake. Supports stall and branch redirect.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   clr            synchronous active-low reset
//   stall          1 = do not start a new memory request
//   branch_taken   1 = redirect the pc to branch_target this cycle
//   branch_target  redirect address
//   mem_req        memory request, held until mem_rdy
//   mem_addr       address of the current request (always equal to pc)
//   mem_rdy        memory returns mem_rdata this cycle
//   mem_rdata      instruction word from memory
//   ir             latched instruction
//   ir_pc          address the latched instruction came from
//   ir_valid       ir/ir_pc hold a valid instruction
//   ir_ack         downstream consumes ir this cycle
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ack
);

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_WAIT,
    ST_HOLD
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              issue;

  // A request is on the bus when FETCH is not stalled, or while a request
  // is already in flight (WAIT ignores stall so the handshake completes).
  always_comb begin
    issue = 1'b0;
    case (state)
      ST_FETCH: issue = ~stall;
      ST_WAIT:  issue = 1'b1;
      default:  issue = 1'b0;
    endcase
  end

  // mem_req is forced low during reset so memory never sees a request
  // from an undefined or abandoned state.
  assign mem_req  = clr & issue;
  assign mem_addr = pc;

  // Reset beats branch, branch beats everything else. A branch drops any
  // word returning in the same cycle and cancels a pending ack. A word that
  // arrives in the same cycle the request is raised (1-cycle memory) is
  // captured directly, skipping WAIT.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= ST_FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else if (branch_taken) begin
      state    <= ST_FETCH;
      pc       <= branch_target;
      ir_valid <= 1'b0;
    end else begin
      case (state)
        ST_FETCH, ST_WAIT: begin
          if (issue && mem_rdy) begin
            ir       <= mem_rdata;
            ir_pc    <= pc;
            pc       <= pc + 1'b1;
            ir_valid <= 1'b1;
            state    <= ST_HOLD;
          end else if (issue) begin
            state <= ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (ir_ack) begin
            ir_valid <= 1'b0;
            state    <= ST_FETCH;
          end
        end
        default: begin
          state    <= ST_FETCH;
          ir_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Bench for fetch_unit. Two instances share every input: one resets to
//   pc 0, the other to pc FFFF so the wrap case is exercised alongside the
//   normal one. A transaction-level model (instruction slot plus an
//   outstanding-request flag) predicts every output each cycle. Directed
//   scenarios come first, followed by randomized traffic.
module tb_fetch_unit;

  logic        clk;
  logic        clr;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        mem_rdy;
  logic [15:0] mem_rdata;
  logic        ir_ack;

  logic        mem_req  [2];
  logic [15:0] mem_addr [2];
  logic [15:0] ir       [2];
  logic [15:0] ir_pc    [2];
  logic        ir_valid [2];

  // reference model state, one slot per instance
  logic [15:0] m_pc      [2];
  logic [15:0] m_ir      [2];
  logic [15:0] m_ir_pc   [2];
  logic        m_valid   [2];
  logic        m_pending [2];
  logic [15:0] m_reset_pc [2];

  int checks = 0;
  int errors = 0;

  fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) dut0 (
    .clk(clk), .clr(clr), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .mem_req(mem_req[0]), .mem_addr(mem_addr[0]),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .ir(ir[0]), .ir_pc(ir_pc[0]),
    .ir_valid(ir_valid[0]), .ir_ack(ir_ack)
  );

  fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'hFFFF)) dut1 (
    .clk(clk), .clr(clr), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .mem_req(mem_req[1]), .mem_addr(mem_addr[1]),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .ir(ir[1]), .ir_pc(ir_pc[1]),
    .ir_valid(ir_valid[1]), .ir_ack(ir_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // A request is visible whenever the slot is empty and either one is
  // already outstanding or the stage is allowed to start one.
  function automatic logic model_req(input int i);
    return clr && !m_valid[i] && (m_pending[i] || !stall);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i]      = m_reset_pc[i];
      m_ir[i]      = 16'h0000;
      m_ir_pc[i]   = 16'h0000;
      m_valid[i]   = 1'b0;
      m_pending[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic req;
    for (int i = 0; i < 2; i++) begin
      req = model_req(i);
      if (!clr) begin
        m_pc[i]      = m_reset_pc[i];
        m_ir[i]      = 16'h0000;
        m_ir_pc[i]   = 16'h0000;
        m_valid[i]   = 1'b0;
        m_pending[i] = 1'b0;
      end else if (branch_taken) begin
        m_pc[i]      = branch_target;
        m_valid[i]   = 1'b0;
        m_pending[i] = 1'b0;
      end else if (m_valid[i]) begin
        if (ir_ack) m_valid[i] = 1'b0;
      end else if (req) begin
        if (mem_rdy) begin
          m_ir[i]      = mem_rdata;
          m_ir_pc[i]   = m_pc[i];
          m_pc[i]      = m_pc[i] + 16'd1;
          m_valid[i]   = 1'b1;
          m_pending[i] = 1'b0;
        end else begin
          m_pending[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("req%0d", i),   {31'd0, mem_req[i]},  {31'd0, model_req(i)});
      checkOutput($sformatf("addr%0d", i),  {16'd0, mem_addr[i]}, {16'd0, m_pc[i]});
      checkOutput($sformatf("ir%0d", i),    {16'd0, ir[i]},       {16'd0, m_ir[i]});
      checkOutput($sformatf("irpc%0d", i),  {16'd0, ir_pc[i]},    {16'd0, m_ir_pc[i]});
      checkOutput($sformatf("valid%0d", i), {31'd0, ir_valid[i]}, {31'd0, m_valid[i]});
    end
  endtask

  // Drive one cycle's inputs after the falling edge, check outputs against
  // the model, then advance the model on the rising edge.
  task automatic applyStimulus(input logic n_clr, input logic st, input logic br,
                               input logic [15:0] tgt, input logic rdy,
                               input logic [15:0] data, input logic ack);
    clr           = n_clr;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    mem_rdy       = rdy;
    mem_rdata     = data;
    ir_ack        = ack;
    #1;
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    m_reset_pc[0] = 16'h0000;
    m_reset_pc[1] = 16'hFFFF;

    // bring both instances out of an undefined power-up state
    clr = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    mem_rdy = 1'b0; mem_rdata = 16'h0000; ir_ack = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);

    $display("[TB] reset with competing inputs");
    applyStimulus(0, 0, 1, 16'h1234, 1, 16'hBEEF, 1);
    applyStimulus(0, 0, 1, 16'h1234, 1, 16'hBEEF, 1);
    checkOutput("t1_pc", {16'd0, mem_addr[0]}, 32'h0000);
    checkOutput("t1_valid", {31'd0, ir_valid[0]}, 32'd0);

    $display("[TB] sequential fetch, 2-cycle memory");
    applyStimulus(1, 0, 0, 16'h0000, 0, 16'h0000, 0);
    applyStimulus(1, 0, 0, 16'h0000, 1, 16'hA001, 0);
    checkOutput("t2_ir1", {16'd0, ir[0]}, 32'hA001);
    checkOutput("t2_irpc1", {16'd0, ir_pc[0]}, 32'h0000);
    checkOutput("t2_valid1", {31'd0, ir_valid[0]}, 32'd1);
    applyStimulus(1, 0, 0, 16'h0000, 0, 16'h0000, 1);
    applyStimulus(1, 0, 0, 16'h0000, 0, 16'h0000, 0);
    applyStimulus(1, 0, 0, 16'h0000, 1, 16'hA002, 0);
    checkOutput("t2_ir2", {16'd0, ir[0]}, 32'hA002);
    checkOutput("t2_irpc2", {16'd0, ir_pc[0]}, 32'h0001);
    checkOutput("t2_pc", {16'd0, mem_addr[0]}, 32'h0002);
    applyStimulus(1, 0, 0, 16'h0000, 0, 16'h0000, 1);

    $display("[TB] stall in FETCH and in WAIT");
    for (int k = 0; k < 4; k++) applyStimulus(1, 1, 0, 16'h0000, 1, 16'h1111, 0);
    checkOutput("t3_pc", {16'd0, mem_addr[0]}, 32'h0002);
    checkOutput("t3_req", {31'd0, mem_req[0]}, 32'd0);
    applyStimulus(1, 0, 0, 16'h0000, 0, 16'h0000, 0);
    applyStimulus(1, 1, 0, 16'h0000, 0, 16'h0000, 0);
    checkOutput("t3_waitreq", {31'd0, mem_req[0]}, 32'd1);
    applyStimulus(1, 1, 0, 16'h0000, 1, 16'h3333, 0);
    applyStimulus(1, 0, 0, 16'h0000, 0, 16'h0000, 1);

    $display("[TB] branch collides with returning word");
    applyStimulus(1, 1, 1, 16'h0005, 0, 16'h0000, 0);
    applyStimulus(1, 0, 0, 16'h0000, 0, 16'h0000, 0);
    applyStimulus(1, 0, 1, 16'h0040, 1, 16'hDEAD, 0);
    checkOutput("t4_valid", {31'd0, ir_valid[0]}, 32'd0);
    checkOutput("t4_addr", {16'd0, mem_addr[0]}, 32'h0040);
    checkOutput("t4_ir", {16'd0, ir[0]}, 32'h3333);

    $display("[TB] pc wrap and backpressure");
    applyStimulus(0, 0, 0, 16'h0000, 0, 16'h0000, 0);
    applyStimulus(1, 0, 0, 16'h0000, 1, 16'h5555, 0);
    checkOutput("t5_irpc", {16'd0, ir_pc[1]}, 32'hFFFF);
    checkOutput("t5_pc", {16'd0, mem_addr[1]}, 32'h0000);
    for (int k = 0; k < 10; k++) applyStimulus(1, 0, 0, 16'h0000, 1, 16'h7777, 0);
    checkOutput("t6_ir", {16'd0, ir[0]}, 32'h5555);
    checkOutput("t6_req", {31'd0, mem_req[0]}, 32'd0);
    applyStimulus(1, 0, 0, 16'h0000, 0, 16'h0000, 1);
    checkOutput("t6_valid", {31'd0, ir_valid[0]}, 32'd0);
    checkOutput("t6_newreq", {31'd0, mem_req[0]}, 32'd1);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 600; k++) begin
      applyStimulus(($urandom_range(0, 49) != 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 9) == 0),
                    16'($urandom),
                    ($urandom_range(0, 1) == 1),
                    16'($urandom),
                    ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
